// File: rtl/vga_timing_pkg.sv
// Shared timing constants, default counter widths and decoder FSM states
// for the pong VGA receive path.
package vga_timing_pkg;

  localparam logic [10:0] H_TOTAL  = 11'd1328;
  localparam logic [10:0] V_TOTAL  = 11'd806;
  localparam logic [10:0] H_ACTIVE = 11'd1024;
  localparam logic [10:0] V_ACTIVE = 11'd768;

  localparam int DEF_H_CNT_W = 32'd11;
  localparam int DEF_V_CNT_W = 32'd11;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    CONFIRM = 2'd2,
    LOCKED  = 2'd3
  } sync_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// Normalises one sync input to active-high, registers it and flags the
// cycle in which the registered level first becomes asserted.
module vga_sync_edge #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic pixelClock,
  input  logic reset,
  input  logic sync_raw,
  output logic rise
);

  logic level_r;
  logic level_d_r;

  // Normalised level plus one cycle of history for the edge detector.
  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      level_r   <= 1'b0;
      level_d_r <= 1'b0;
    end else begin
      level_r   <= sync_raw ^ ACTIVE_LOW;
      level_d_r <= level_r;
    end
  end

  assign rise = level_r & ~level_d_r;

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: recovers pixel coordinates, measures the
// line/frame mode, locks onto it, counts bad frames and checksums each frame.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_CNT_W          = DEF_H_CNT_W,
  parameter int V_CNT_W          = DEF_V_CNT_W,
  parameter bit HSYNC_ACTIVE_LOW = 1'b1,
  parameter bit VSYNC_ACTIVE_LOW = 1'b1,
  parameter int LOCK_FRAMES      = 32'd2
) (
  input  logic               pixelClock,
  input  logic               reset,
  input  logic               hSyncIn,
  input  logic               vSyncIn,
  input  logic               blankNIn,
  input  logic [7:0]         rIn,
  input  logic [7:0]         gIn,
  input  logic [7:0]         bIn,
  output logic [H_CNT_W-1:0] xPixel,
  output logic [V_CNT_W-1:0] yPixel,
  output logic               pixelValid,
  output logic [23:0]        pixelColor,
  output logic               frameStart,
  output logic               locked,
  output logic [H_CNT_W-1:0] hTotal,
  output logic [V_CNT_W-1:0] vTotal,
  output logic [H_CNT_W-1:0] hActive,
  output logic [V_CNT_W-1:0] vActive,
  output logic [23:0]        frameSum,
  output logic               frameSumValid,
  output logic [7:0]         errorCount
);

  localparam logic [H_CNT_W-1:0] H_ONE = H_CNT_W'(1'b1);
  localparam logic [V_CNT_W-1:0] V_ONE = V_CNT_W'(1'b1);

  function automatic logic [H_CNT_W-1:0] sat_inc_h(input logic [H_CNT_W-1:0] v);
    return (v == '1) ? v : v + H_ONE;
  endfunction

  function automatic logic [V_CNT_W-1:0] sat_inc_v(input logic [V_CNT_W-1:0] v);
    return (v == '1) ? v : v + V_ONE;
  endfunction

  logic hs_rise, vs_rise;
  logic act_r;
  logic [23:0] rgb_r;
  logic [H_CNT_W-1:0] line_cnt_r, x_cnt_r;
  logic line_act_r;
  logic [V_CNT_W-1:0] y_cnt_r;
  logic [V_CNT_W-1:0] lines_r, act_lines_r;
  logic [H_CNT_W-1:0] last_act_r, last_len_r;
  logic bad_r;
  logic [23:0] sum_r;
  sync_state_t state_r;
  logic [7:0] match_r;

  logic [H_CNT_W-1:0] line_len_s, cur_x_s, line_pix_s;
  logic line_has_s;
  logic [V_CNT_W-1:0] f_lines_s, f_act_lines_s;
  logic [H_CNT_W-1:0] f_last_act_s, f_last_len_s;
  logic f_bad_s, frame_ok_s;
  logic [23:0] f_sum_s;
  logic [7:0] match_next_s;

  vga_sync_edge #(.ACTIVE_LOW(HSYNC_ACTIVE_LOW)) u_hs_edge (
    .pixelClock(pixelClock), .reset(reset), .sync_raw(hSyncIn), .rise(hs_rise)
  );

  vga_sync_edge #(.ACTIVE_LOW(VSYNC_ACTIVE_LOW)) u_vs_edge (
    .pixelClock(pixelClock), .reset(reset), .sync_raw(vSyncIn), .rise(vs_rise)
  );

  // Frame totals as they stand including this cycle, so a line closed by a
  // coincident hsRise still belongs to the frame that vsRise is ending.
  always_comb begin
    line_len_s    = (line_cnt_r == '1) ? line_cnt_r : line_cnt_r + H_ONE;
    cur_x_s       = line_act_r ? x_cnt_r : '0;
    line_pix_s    = act_r ? cur_x_s + H_ONE : cur_x_s;
    line_has_s    = act_r | line_act_r;
    f_lines_s     = hs_rise ? sat_inc_v(lines_r) : lines_r;
    f_act_lines_s = (hs_rise && line_has_s) ? sat_inc_v(act_lines_r) : act_lines_r;
    f_last_act_s  = (hs_rise && line_has_s) ? line_pix_s : last_act_r;
    f_last_len_s  = hs_rise ? line_len_s : last_len_r;
    f_bad_s       = bad_r | (hs_rise && (line_len_s != hTotal));
    f_sum_s       = sum_r + (act_r ? rgb_r : 24'h000000);
    frame_ok_s    = !f_bad_s && (f_lines_s == vTotal) && (f_act_lines_s == vActive) &&
                    (f_last_act_s == hActive) && (f_last_len_s == hTotal);
    match_next_s  = match_r + 8'd1;
  end

  // Input stage, pixel output stage and line/x/y counters.
  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      act_r      <= 1'b0;
      rgb_r      <= 24'h000000;
      pixelValid <= 1'b0;
      pixelColor <= 24'h000000;
      xPixel     <= '0;
      yPixel     <= '0;
      line_cnt_r <= '0;
      x_cnt_r    <= '0;
      line_act_r <= 1'b0;
      y_cnt_r    <= '0;
    end else begin
      act_r      <= blankNIn;
      rgb_r      <= {rIn, gIn, bIn};
      pixelValid <= act_r;
      if (act_r) begin
        xPixel     <= cur_x_s;
        yPixel     <= y_cnt_r;
        pixelColor <= rgb_r;
      end
      line_cnt_r <= hs_rise ? '0 : sat_inc_h(line_cnt_r);
      if (hs_rise) begin
        line_act_r <= 1'b0;
      end else if (act_r) begin
        line_act_r <= 1'b1;
        x_cnt_r    <= line_pix_s;
      end
      if (vs_rise) begin
        y_cnt_r <= '0;
      end else if (hs_rise && line_has_s) begin
        y_cnt_r <= sat_inc_v(y_cnt_r);
      end
    end
  end

  // Per-frame accumulators, restarted at every vsRise.
  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset || vs_rise) begin
      lines_r     <= '0;
      act_lines_r <= '0;
      last_act_r  <= '0;
      last_len_r  <= '0;
      bad_r       <= 1'b0;
      sum_r       <= 24'h000000;
    end else begin
      lines_r     <= f_lines_s;
      act_lines_r <= f_act_lines_s;
      last_act_r  <= f_last_act_s;
      last_len_r  <= f_last_len_s;
      bad_r       <= f_bad_s;
      sum_r       <= f_sum_s;
    end
  end

  // Mode lock FSM with its registered status outputs.
  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      state_r       <= SEARCH;
      match_r       <= 8'd0;
      frameStart    <= 1'b0;
      frameSumValid <= 1'b0;
      frameSum      <= 24'h000000;
      locked        <= 1'b0;
      errorCount    <= 8'd0;
      hTotal        <= '0;
      vTotal        <= '0;
      hActive       <= '0;
      vActive       <= '0;
    end else begin
      frameStart    <= vs_rise;
      frameSumValid <= 1'b0;
      case (state_r)
        SEARCH: begin
          if (vs_rise) state_r <= MEASURE;
        end
        MEASURE: begin
          if (vs_rise) begin
            frameSumValid <= 1'b1;
            frameSum      <= f_sum_s;
            hTotal        <= f_last_len_s;
            vTotal        <= f_lines_s;
            hActive       <= f_last_act_s;
            vActive       <= f_act_lines_s;
            match_r       <= 8'd0;
            state_r       <= CONFIRM;
          end
        end
        CONFIRM, LOCKED: begin
          if (vs_rise) begin
            frameSumValid <= 1'b1;
            frameSum      <= f_sum_s;
            if (frame_ok_s) begin
              if (state_r == CONFIRM) begin
                match_r <= match_next_s;
                if (match_next_s == 8'(LOCK_FRAMES)) begin
                  locked  <= 1'b1;
                  state_r <= LOCKED;
                end
              end
            end else begin
              // The failing frame is taken as the new measurement.
              errorCount <= (errorCount == 8'hFF) ? errorCount : errorCount + 8'd1;
              locked     <= 1'b0;
              hTotal     <= f_last_len_s;
              vTotal     <= f_lines_s;
              hActive    <= f_last_act_s;
              vActive    <= f_act_lines_s;
              state_r    <= MEASURE;
            end
          end
        end
        default: begin
          state_r <= SEARCH;
          locked  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled-down 24x14 clock mode
// (10x8 active) so many frames fit in a short run.
module tb_vga_sync_decoder;

  localparam int H_TOT    = 24;
  localparam int H_ACT    = 10;
  localparam int V_TOT    = 14;
  localparam int V_ACT    = 8;
  localparam int HS_START = 14;
  localparam int HS_LEN   = 4;
  localparam int VS_LINE  = 10;

  logic        pixelClock = 1'b0;
  logic        reset      = 1'b1;
  logic        hSyncIn    = 1'b1;
  logic        vSyncIn    = 1'b1;
  logic        blankNIn   = 1'b0;
  logic [7:0]  rIn = 8'd0, gIn = 8'd0, bIn = 8'd0;
  logic [10:0] xPixel, yPixel, hTotal, vTotal, hActive, vActive;
  logic        pixelValid, frameStart, locked, frameSumValid;
  logic [23:0] pixelColor, frameSum;
  logic [7:0]  errorCount;

  int n_checks = 0;
  int n_bad    = 0;
  int stray    = 0;
  int vline    = 0;
  int hcol     = 0;
  int color_mode = 1;
  bit shorten    = 1'b0;
  bit vs_aligned = 1'b0;

  vga_sync_decoder dut (
    .pixelClock(pixelClock), .reset(reset),
    .hSyncIn(hSyncIn), .vSyncIn(vSyncIn), .blankNIn(blankNIn),
    .rIn(rIn), .gIn(gIn), .bIn(bIn),
    .xPixel(xPixel), .yPixel(yPixel), .pixelValid(pixelValid), .pixelColor(pixelColor),
    .frameStart(frameStart), .locked(locked),
    .hTotal(hTotal), .vTotal(vTotal), .hActive(hActive), .vActive(vActive),
    .frameSum(frameSum), .frameSumValid(frameSumValid), .errorCount(errorCount)
  );

  always #5 pixelClock = ~pixelClock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic any_output();
    return |{xPixel, yPixel, pixelValid, pixelColor, frameStart, locked, hTotal, vTotal,
             hActive, vActive, frameSum, frameSumValid, errorCount};
  endfunction

  // Drive one clock of video for the current raster position, then advance it.
  task tick();
    int  p;
    int  vs_start;
    bit  act;
    p        = vline * H_TOT + hcol;
    vs_start = VS_LINE * H_TOT + (vs_aligned ? HS_START : 2);
    act      = (hcol < H_ACT) && (vline < V_ACT);
    hSyncIn  = !((hcol >= HS_START) && (hcol < HS_START + HS_LEN));
    vSyncIn  = !((p >= vs_start) && (p < vs_start + 2 * H_TOT));
    blankNIn = act;
    case (color_mode)
      1:       {rIn, gIn, bIn} = 24'hFFFFFF;
      2:       {rIn, gIn, bIn} = (vline == 7 && hcol == 5) ? 24'h123456 : 24'h000000;
      default: {rIn, gIn, bIn} = 24'h000000;
    endcase
    @(posedge pixelClock);
    #1;
    if (frameSumValid && !frameStart) stray++;
    hcol++;
    if (shorten && vline == 3 && hcol == 20) begin
      hcol    = 21;
      shorten = 1'b0;
    end
    if (hcol == H_TOT) begin
      hcol  = 0;
      vline = (vline == V_TOT - 1) ? 0 : vline + 1;
    end
  endtask

  task wait_fs();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!frameStart && n < 1000);
    chk("frame_start_seen", 32'(frameStart), 32'd1);
  endtask

  task run_to(input int l, input int c);
    int n;
    n = 0;
    while (!(vline == l && hcol == c) && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) chk("run_to_position", 32'(vline * H_TOT + hcol), 32'(l * H_TOT + c));
  endtask

  initial begin
    repeat (3) @(posedge pixelClock);
    #1;
    chk("reset_outputs_zero", 32'(any_output()), 32'd0);
    reset = 1'b0;

    // Lock sequence on an all-white picture: 80 pixels of 0xFFFFFF.
    wait_fs();
    chk("fs1_sum_valid", 32'(frameSumValid), 32'd0);
    chk("fs1_h_total", 32'(hTotal), 32'd0);
    chk("blank_pixel_valid", 32'(pixelValid), 32'd0);
    wait_fs();
    chk("fs2_sum_valid", 32'(frameSumValid), 32'd1);
    chk("fs2_h_total", 32'(hTotal), 32'd24);
    chk("fs2_v_total", 32'(vTotal), 32'd14);
    chk("fs2_h_active", 32'(hActive), 32'd10);
    chk("fs2_v_active", 32'(vActive), 32'd8);
    chk("fs2_locked", 32'(locked), 32'd0);
    chk("fs2_white_sum", 32'(frameSum), 32'hFFFFB0);
    wait_fs();
    chk("fs3_locked", 32'(locked), 32'd0);
    wait_fs();
    chk("fs4_locked", 32'(locked), 32'd1);
    chk("fs4_error_count", 32'(errorCount), 32'd0);
    chk("fs4_white_sum", 32'(frameSum), 32'hFFFFB0);

    // One 23-clock line inside a locked frame.
    shorten = 1'b1;
    wait_fs();
    chk("short_line_locked", 32'(locked), 32'd0);
    chk("short_line_errors", 32'(errorCount), 32'd1);
    wait_fs();
    chk("relock1_locked", 32'(locked), 32'd0);
    wait_fs();
    chk("relock2_locked", 32'(locked), 32'd0);
    wait_fs();
    chk("relock3_locked", 32'(locked), 32'd1);
    chk("relock3_h_total", 32'(hTotal), 32'd24);

    color_mode = 0;
    wait_fs();
    chk("black_sum", 32'(frameSum), 32'h000000);

    color_mode = 2;
    run_to(7, 5);
    tick();
    tick();
    chk("pix_valid", 32'(pixelValid), 32'd1);
    chk("pix_x", 32'(xPixel), 32'd5);
    chk("pix_y", 32'(yPixel), 32'd7);
    chk("pix_color", 32'(pixelColor), 32'h123456);
    wait_fs();
    chk("single_pixel_sum", 32'(frameSum), 32'h123456);
    chk("single_errors", 32'(errorCount), 32'd1);
    chk("single_locked", 32'(locked), 32'd1);

    // Mid-frame reset, then restart with vsRise coincident with hsRise.
    run_to(4, 0);
    reset = 1'b1;
    #1;
    chk("midframe_reset_zero", 32'(any_output()), 32'd0);
    vs_aligned = 1'b1;
    color_mode = 1;
    repeat (3) tick();
    reset = 1'b0;
    wait_fs();
    chk("rst_fs1_sum_valid", 32'(frameSumValid), 32'd0);
    chk("rst_fs1_v_total", 32'(vTotal), 32'd0);
    wait_fs();
    chk("rst_fs2_sum_valid", 32'(frameSumValid), 32'd1);
    chk("rst_fs2_v_total", 32'(vTotal), 32'd14);
    chk("rst_fs2_h_total", 32'(hTotal), 32'd24);
    chk("rst_fs2_sum", 32'(frameSum), 32'hFFFFB0);
    wait_fs();
    chk("rst_fs3_locked", 32'(locked), 32'd0);
    wait_fs();
    chk("aligned_locked", 32'(locked), 32'd1);
    chk("aligned_v_total", 32'(vTotal), 32'd14);
    chk("aligned_errors", 32'(errorCount), 32'd0);

    chk("stray_sum_valid", 32'(stray), 32'd0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
